// File: rtl/spi_mem_bridge_if.sv
// Byte-level link between the SPI slave front end, the command bridge and a
// synchronous byte-wide memory.
interface spi_mem_bridge_if #(parameter int ADDR_W = 8);
  // Handshake: strobes, not valid/ready. rx_strobe marks rx_byte valid for
  // exactly one SCLK cycle and there is no backpressure. mem_we and mem_re are
  // one-cycle commands, and mem_rdata is sampled on the edge that ends mem_re.
  logic              cs_n;
  logic [7:0]        rx_byte;
  logic              rx_strobe;
  logic [7:0]        tx_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              illegal_cmd;

  modport slave (
    input  cs_n, rx_byte, rx_strobe, mem_rdata,
    output tx_byte, mem_addr, mem_wdata, mem_we, mem_re, illegal_cmd
  );

  modport master (
    output cs_n, rx_byte, rx_strobe, mem_rdata,
    input  tx_byte, mem_addr, mem_wdata, mem_we, mem_re, illegal_cmd
  );
endinterface

// File: rtl/spi_mem_bridge.sv
// Frame decoder: command, address and data bytes from the SPI slave become
// single-cycle memory strobes, with read data returned on tx_byte.
module spi_mem_bridge #(
  parameter int ADDR_W = 8
) (
  input  logic            SCLK,
  input  logic            reset,
  spi_mem_bridge_if.slave bus,
  output logic [2:0]      fsm_state
);
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR_W  = 3'd1,
    GET_ADDR_R  = 3'd2,
    WR_DATA     = 3'd3,
    RD_PREFETCH = 3'd4,
    RD_DATA     = 3'd5,
    STATUS      = 3'd6,
    IGNORE      = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d, re_q, re_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q, tx_q;
  logic [3:0]        wr_count;
  logic              ill_q;
  logic              load_addr, load_wdata, load_status, load_rd, set_ill, clr_ill;
  logic              stb, abort;

  // A strobe that arrives with cs_n high, or while a read is in flight, is dropped.
  assign abort = reset | bus.cs_n;
  assign stb   = bus.rx_strobe & ~bus.cs_n & ~re_q;

  always_ff @(posedge SCLK or posedge abort) begin
    if (abort) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    load_addr   = 1'b0;
    load_wdata  = 1'b0;
    load_status = 1'b0;
    load_rd     = 1'b0;
    set_ill     = 1'b0;
    clr_ill     = 1'b0;
    case (state_q)
      IDLE: begin
        if (stb) begin
          case (bus.rx_byte)
            8'h02:   state_d = GET_ADDR_W;
            8'h03:   state_d = GET_ADDR_R;
            8'h05: begin
              state_d     = STATUS;
              load_status = 1'b1;
            end
            default: begin
              state_d = IGNORE;
              set_ill = 1'b1;
            end
          endcase
        end
      end
      GET_ADDR_W: begin
        if (stb) begin
          load_addr = 1'b1;
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (stb) begin
          we_d       = 1'b1;
          load_wdata = 1'b1;
        end
      end
      GET_ADDR_R: begin
        if (stb) begin
          load_addr = 1'b1;
          re_d      = 1'b1;
          state_d   = RD_PREFETCH;
        end
      end
      RD_PREFETCH: begin
        load_rd = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (stb) begin
          re_d    = 1'b1;
          state_d = RD_PREFETCH;
        end
      end
      STATUS: begin
        if (stb) clr_ill = 1'b1;
      end
      IGNORE: begin
        state_d = IGNORE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address, counters and status survive a cs_n abort; only reset clears them.
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      tx_q     <= 8'h00;
      wr_count <= 4'd0;
      ill_q    <= 1'b0;
    end else begin
      if (load_addr)
        addr_q <= bus.rx_byte[ADDR_W-1:0];
      else if (we_q || load_rd)
        addr_q <= addr_q + ADDR_W'(1);
      if (we_q)
        wr_count <= wr_count + 4'd1;
      if (load_wdata)
        wdata_q <= bus.rx_byte;
      if (load_status)
        tx_q <= {wr_count, 2'b00, ill_q, 1'b0};
      else if (load_rd)
        tx_q <= bus.mem_rdata;
      if (set_ill)
        ill_q <= 1'b1;
      else if (clr_ill)
        ill_q <= 1'b0;
    end
  end

  assign bus.tx_byte     = tx_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_re      = re_q;
  assign bus.illegal_cmd = ill_q;
  assign fsm_state       = state_q;
endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: a frame-level reference model, a per-cycle
// compare process, directed protocol cases and randomized frames.
module tb_spi_mem_bridge;
  localparam int ADDR_W = 8;

  logic       SCLK = 1'b0;
  logic       reset;
  logic [2:0] fsm_state;
  logic       init_mem;
  logic       mon_en;

  spi_mem_bridge_if #(.ADDR_W(ADDR_W)) bus();

  spi_mem_bridge #(.ADDR_W(ADDR_W)) dut (
    .SCLK      (SCLK),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 SCLK = ~SCLK;

  // Environment memory written by the DUT; ref_mem is the model's own copy.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge SCLK) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Scoreboard and model state
  logic [15:0] exp_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  m_tx, m_addr;
  logic [3:0]  m_wr;
  logic        m_ill;
  int          re_pulses;
  int          n_cmp, n_err;
  int          f_kind, f_idx;
  logic [7:0]  tx_cap[8];

  localparam int K_NONE = 0, K_WR = 1, K_RD = 2, K_ST = 3, K_IGN = 4;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge SCLK) begin
    if (mon_en) begin
      chk("tx_byte", 16'(bus.tx_byte), 16'(m_tx));
      chk("mem_addr", 16'(bus.mem_addr), 16'(m_addr));
      chk("illegal_cmd", 16'(bus.illegal_cmd), 16'(m_ill));
      chk("we_re_exclusive", 16'(bus.mem_we & bus.mem_re), 16'd0);
      if (bus.mem_we) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          chk("write", {bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
        end
      end
      if (bus.mem_re) begin
        re_pulses++;
        if (exp_rd_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_read: addr 0x%0h, expected no read", bus.mem_addr);
        end else begin
          chk("read_addr", 16'(bus.mem_addr), 16'(exp_rd_q.pop_front()));
        end
      end
    end
  end

  // Model effects visible right after the strobe's sampling edge.
  task automatic model_edge_k(input logic [7:0] b);
    if (f_idx == 0) begin
      case (b)
        8'h02: f_kind = K_WR;
        8'h03: f_kind = K_RD;
        8'h05: begin
          f_kind = K_ST;
          m_tx   = {m_wr, 2'b00, m_ill, 1'b0};
        end
        default: begin
          f_kind = K_IGN;
          m_ill  = 1'b1;
        end
      endcase
    end else if (f_kind == K_WR) begin
      if (f_idx == 1) m_addr = b;
      else begin
        exp_q.push_back({m_addr, b});
        ref_mem[m_addr] = b;
      end
    end else if (f_kind == K_RD) begin
      if (f_idx == 1) m_addr = b;
      exp_rd_q.push_back(m_addr);
    end else if (f_kind == K_ST) begin
      m_ill = 1'b0;
    end
  endtask

  // Model effects visible one edge later (address advance, read return).
  task automatic model_edge_k1();
    if (f_kind == K_WR && f_idx >= 2) begin
      m_addr = m_addr + 8'd1;
      m_wr   = m_wr + 4'd1;
    end else if (f_kind == K_RD && f_idx >= 1) begin
      m_tx   = ref_mem[m_addr];
      m_addr = m_addr + 8'd1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte   = b;
    bus.rx_strobe = 1'b1;
    @(posedge SCLK); #1;
    bus.rx_strobe = 1'b0;
    model_edge_k(b);
    @(posedge SCLK); #1;
    model_edge_k1();
    if (f_idx < 8) tx_cap[f_idx] = bus.tx_byte;
    f_idx++;
    repeat (6) @(posedge SCLK);
    #1;
  endtask

  task automatic start_frame();
    bus.cs_n = 1'b0;
    f_idx    = 0;
    f_kind   = K_NONE;
    repeat (2) @(posedge SCLK);
    #1;
  endtask

  task automatic end_frame();
    bus.cs_n = 1'b1;
    repeat (3) @(posedge SCLK);
    #1;
    chk("writes_drained", 16'(exp_q.size()), 16'd0);
    chk("reads_drained", 16'(exp_rd_q.size()), 16'd0);
    exp_q.delete();
    exp_rd_q.delete();
  endtask

  task automatic model_reset();
    m_tx   = 8'h00;
    m_addr = 8'h00;
    m_wr   = 4'd0;
    m_ill  = 1'b0;
    f_idx  = 0;
    f_kind = K_NONE;
    exp_q.delete();
    exp_rd_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] cmd, len;
    n_cmp = 0; n_err = 0; re_pulses = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    bus.cs_n = 1'b1;
    bus.rx_strobe = 1'b0;
    bus.rx_byte = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    ref_mem[8'h20] = 8'hC3;
    ref_mem[8'h40] = 8'h77;
    ref_mem[8'h50] = 8'h66;
    init_mem = 1'b1;
    model_reset();
    repeat (2) @(posedge SCLK);
    #1;
    init_mem = 1'b0;

    chk("reset_tx_byte", 16'(bus.tx_byte), 16'h00);
    chk("reset_mem_addr", 16'(bus.mem_addr), 16'h00);
    chk("reset_mem_wdata", 16'(bus.mem_wdata), 16'h00);
    chk("reset_mem_we", 16'(bus.mem_we), 16'd0);
    chk("reset_mem_re", 16'(bus.mem_re), 16'd0);
    chk("reset_illegal", 16'(bus.illegal_cmd), 16'd0);
    reset = 1'b0;
    @(posedge SCLK); #1;
    mon_en = 1'b1;

    // Reset in the middle of a write burst, then decode a fresh WRITE frame.
    start_frame();
    send_byte(8'h02);
    send_byte(8'h30);
    bus.rx_byte = 8'h44;
    bus.rx_strobe = 1'b1;
    @(posedge SCLK); #1;
    bus.rx_strobe = 1'b0;
    chk("we_before_reset", 16'(bus.mem_we), 16'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_we", 16'(bus.mem_we), 16'd0);
    chk("rst_mid_addr", 16'(bus.mem_addr), 16'h00);
    repeat (2) @(posedge SCLK);
    #1;
    reset = 1'b0;
    @(posedge SCLK); #1;
    f_idx = 0;
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'hA5);
    send_byte(8'h5A);
    end_frame();
    chk("wr_mem_10", 16'(mem[8'h10]), 16'hA5);
    chk("wr_mem_11", 16'(mem[8'h11]), 16'h5A);
    chk("wr_mem_30_untouched", 16'(mem[8'h30]), 16'(ref_mem[8'h30]));

    // Burst read with one dummy byte.
    re_pulses = 0;
    start_frame();
    send_byte(8'h03);
    send_byte(8'h10);
    send_byte(8'h00);
    end_frame();
    chk("rd_tx_first", 16'(tx_cap[1]), 16'hA5);
    chk("rd_tx_second", 16'(tx_cap[2]), 16'h5A);
    chk("rd_re_pulses", 16'(re_pulses), 16'd2);

    // Address wrap at the top of memory.
    start_frame();
    send_byte(8'h02);
    send_byte(8'hFF);
    send_byte(8'h12);
    send_byte(8'h34);
    end_frame();
    chk("wrap_mem_ff", 16'(mem[8'hFF]), 16'h12);
    chk("wrap_mem_00", 16'(mem[8'h00]), 16'h34);
    chk("wrap_addr", 16'(bus.mem_addr), 16'h01);

    // Illegal command swallows the rest of the frame.
    start_frame();
    send_byte(8'h7E);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    end_frame();
    chk("illegal_set", 16'(bus.illegal_cmd), 16'd1);
    chk("illegal_no_write", 16'(mem[8'h00]), 16'h34);

    // Status: four writes so far, illegal flag set.
    start_frame();
    send_byte(8'h05);
    chk("status_ill_held", 16'(bus.illegal_cmd), 16'd1);
    send_byte(8'hAA);
    end_frame();
    chk("status_byte", 16'(tx_cap[0]), 16'h42);
    chk("status_repeat", 16'(tx_cap[1]), 16'h42);
    chk("status_ill_clear", 16'(bus.illegal_cmd), 16'd0);

    // Abort right after the write address, then a normal read.
    start_frame();
    send_byte(8'h02);
    send_byte(8'h40);
    end_frame();
    start_frame();
    send_byte(8'h03);
    send_byte(8'h20);
    end_frame();
    chk("abort_rd_tx", 16'(tx_cap[1]), 16'hC3);
    chk("abort_no_write", 16'(mem[8'h40]), 16'h77);

    // cs_n rising in the same cycle as a data strobe drops the byte.
    start_frame();
    send_byte(8'h02);
    send_byte(8'h50);
    bus.rx_byte = 8'h99;
    bus.rx_strobe = 1'b1;
    bus.cs_n = 1'b1;
    @(posedge SCLK); #1;
    bus.rx_strobe = 1'b0;
    end_frame();
    chk("same_cycle_abort", 16'(mem[8'h50]), 16'h66);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: cmd = 8'h02;
        1: cmd = 8'h03;
        2: cmd = 8'h05;
        default: begin
          cmd = 8'($urandom_range(0, 255));
          while (cmd == 8'h02 || cmd == 8'h03 || cmd == 8'h05)
            cmd = 8'($urandom_range(0, 255));
        end
      endcase
      len = 8'($urandom_range(0, 5));
      start_frame();
      send_byte(cmd);
      for (int i = 0; i < int'(len); i++) send_byte(8'($urandom_range(0, 255)));
      end_frame();
    end
    for (int i = 0; i < 256; i++) chk("final_mem", 16'(mem[i]), 16'(ref_mem[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
